// File: rtl/mem_pkg.sv
// Shared constants for the memory/peripheral stage: MMIO addresses, load/store
// size encodings and the address-region type.
package mem_pkg;

  localparam logic [31:0] ADDR_LEDS   = 32'hFFFF_FFFC;
  localparam logic [31:0] ADDR_MILLIS = 32'hFFFF_FFF8;
  localparam logic [31:0] ADDR_MICROS = 32'hFFFF_FFF4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_LEDS,
    REG_MILLIS,
    REG_MICROS,
    REG_NONE
  } region_t;

endpackage

// File: rtl/memory_mmio_pwm_channel.sv
// One PWM comparator; the 8-bit ramp is shared by all channels.
module pwm_channel (
  input  logic [7:0] duty,
  input  logic [7:0] cnt,
  output logic       pwm
);

  assign pwm = (cnt < duty);

endmodule

// File: rtl/memory_mmio.sv
// Unified instruction/data RAM with byte/halfword lanes, micros/millis timers
// and a 4-channel PWM LED register, all behind one synchronous read port.
module memory_mmio
  import mem_pkg::*;
#(
  parameter int    MEM_WORDS   = 2048,
  parameter int    CLK_FREQ_HZ = 12000000,
  parameter string INIT_FILE   = "program.txt"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Adr,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  input  logic [2:0]  funct3,
  output logic [31:0] ReadData,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int AW    = $clog2(MEM_WORDS);
  localparam int PRESC = CLK_FREQ_HZ / 1_000_000;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [31:0] mem [MEM_WORDS];

  region_t     region, region_p1;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [AW-1:0] idx;
  logic        we_ram, we_leds;
  logic [31:0] ram_p1, mmio_p1, word_p1;
  logic [1:0]  lane_p1;
  logic [2:0]  f3_p1;
  logic [31:0] leds, micros, millis;
  logic [PW-1:0] presc;
  logic [9:0]  sub;
  logic [7:0]  pwm_cnt, byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    region = REG_NONE;
    if (Adr < 32'(4 * MEM_WORDS))               region = REG_RAM;
    else if (Adr[31:2] == ADDR_LEDS[31:2])      region = REG_LEDS;
    else if (Adr[31:2] == ADDR_MILLIS[31:2])    region = REG_MILLIS;
    else if (Adr[31:2] == ADDR_MICROS[31:2])    region = REG_MICROS;
  end

  always_comb begin
    be    = 4'b1111;
    wdata = WriteData;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << Adr[1:0];
        wdata = {4{WriteData[7:0]}};
      end
      F3_H: begin
        be    = Adr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  assign idx = Adr[AW+1:2];
  // A store landing on the same edge as reset assertion must not reach the RAM.
  assign we_ram  = MemWrite && !reset && (region == REG_RAM);
  assign we_leds = MemWrite && !reset && (region == REG_LEDS);

  // ---- stage p1: synchronous RAM read (read-first), not reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we_ram && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    ram_p1 <= mem[idx];
  end

  // ---- stage p1: access attributes, MMIO read snapshot, timers, PWM ramp
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      region_p1 <= REG_NONE;
      lane_p1   <= 2'd0;
      f3_p1     <= F3_W;
      mmio_p1   <= 32'd0;
      leds      <= 32'd0;
      micros    <= 32'd0;
      millis    <= 32'd0;
      presc     <= '0;
      sub       <= 10'd0;
      pwm_cnt   <= 8'd0;
    end else begin
      region_p1 <= region;
      lane_p1   <= Adr[1:0];
      f3_p1     <= funct3;
      case (region)
        REG_LEDS:   mmio_p1 <= leds;
        REG_MILLIS: mmio_p1 <= millis;
        REG_MICROS: mmio_p1 <= micros;
        default:    mmio_p1 <= 32'd0;
      endcase
      for (int b = 0; b < 4; b++)
        if (we_leds && be[b]) leds[8*b +: 8] <= wdata[8*b +: 8];
      if (presc == PW'(PRESC - 1)) begin
        presc  <= '0;
        micros <= micros + 32'd1;
        if (sub == 10'd999) begin
          sub    <= 10'd0;
          millis <= millis + 32'd1;
        end else begin
          sub <= sub + 10'd1;
        end
      end else begin
        presc <= presc + PW'(1);
      end
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign word_p1 = (region_p1 == REG_RAM) ? ram_p1 : mmio_p1;

  always_comb begin
    case (lane_p1)
      2'd0:    byte_sel = word_p1[7:0];
      2'd1:    byte_sel = word_p1[15:8];
      2'd2:    byte_sel = word_p1[23:16];
      default: byte_sel = word_p1[31:24];
    endcase
    half_sel = lane_p1[1] ? word_p1[31:16] : word_p1[15:0];
    case (f3_p1)
      F3_B:    ReadData = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ReadData = {24'd0, byte_sel};
      F3_H:    ReadData = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ReadData = {16'd0, half_sel};
      default: ReadData = word_p1;
    endcase
  end

  pwm_channel u_pwm_red   (.duty(leds[31:24]), .cnt(pwm_cnt), .pwm(red));
  pwm_channel u_pwm_green (.duty(leds[23:16]), .cnt(pwm_cnt), .pwm(green));
  pwm_channel u_pwm_blue  (.duty(leds[15:8]),  .cnt(pwm_cnt), .pwm(blue));
  pwm_channel u_pwm_led   (.duty(leds[7:0]),   .cnt(pwm_cnt), .pwm(led));

endmodule

// File: tb/tb_memory_mmio.sv
// Randomized bench for memory_mmio against an arithmetic reference model,
// plus directed literal checks for loads, stores, timers, PWM and reset.
module tb_memory_mmio;

  localparam logic [31:0] A_LEDS   = 32'hFFFF_FFFC;
  localparam logic [31:0] A_MILLIS = 32'hFFFF_FFF8;
  localparam logic [31:0] A_MICROS = 32'hFFFF_FFF4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Adr = 32'd0;
  logic        MemWrite = 1'b0;
  logic [31:0] WriteData = 32'd0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] ReadData;
  logic        led, red, green, blue;

  int tests = 0;
  int fails = 0;
  logic check_en = 1'b0;

  memory_mmio #(.INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .Adr(Adr), .MemWrite(MemWrite),
    .WriteData(WriteData), .funct3(funct3), .ReadData(ReadData),
    .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  // Reference model: RAM window of 256 words (0x000-0x3FF), LEDS register,
  // and a count of clock edges since reset from which timers and ramp follow.
  logic [31:0] mm [256];
  logic [31:0] m_leds = 32'd0;
  int unsigned m_n = 0;
  logic [31:0] exp_rd = 32'd0;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * lane)) & 32'hFF;
    h = (w >> (16 * lane[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b ^ 32'h80) - 32'h80;
      3'b001:  return (h ^ 32'h8000) - 32'h8000;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] mask, data;
    case (f3)
      3'b000: begin
        mask = 32'hFF << (8 * a[1:0]);
        data = (wd & 32'hFF) << (8 * a[1:0]);
      end
      3'b001: begin
        mask = 32'hFFFF << (16 * a[1]);
        data = (wd & 32'hFFFF) << (16 * a[1]);
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wd;
      end
    endcase
    return (old & ~mask) | (data & mask);
  endfunction

  function automatic logic [31:0] cur_word(input logic [31:0] a);
    if (a < 32'h400)                      return mm[a[9:2]];
    else if (a < 32'h2000)                return 32'hx;
    else if (a[31:2] == A_LEDS[31:2])     return m_leds;
    else if (a[31:2] == A_MILLIS[31:2])   return m_n / 12000;
    else if (a[31:2] == A_MICROS[31:2])   return m_n / 12;
    return 32'd0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_leds <= 32'd0;
      m_n    <= 0;
      exp_rd <= 32'd0;
    end else begin
      exp_rd <= extract(cur_word(Adr), Adr[1:0], funct3);
      if (MemWrite && Adr < 32'h400) mm[Adr[9:2]] <= merge(mm[Adr[9:2]], WriteData, Adr, funct3);
      if (MemWrite && Adr[31:2] == A_LEDS[31:2]) m_leds <= merge(m_leds, WriteData, Adr, funct3);
      m_n <= m_n + 1;
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      lit("rd",    ReadData, exp_rd);
      lit("red",   {31'd0, red},   {31'd0, (m_n % 256) < m_leds[31:24]});
      lit("green", {31'd0, green}, {31'd0, (m_n % 256) < m_leds[23:16]});
      lit("blue",  {31'd0, blue},  {31'd0, (m_n % 256) < m_leds[15:8]});
      lit("led",   {31'd0, led},   {31'd0, (m_n % 256) < m_leds[7:0]});
    end
  end

  task automatic access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [2:0] f3);
    Adr = a; MemWrite = we; WriteData = wd; funct3 = f3;
    @(posedge clk); #2;
    MemWrite = 1'b0;
  endtask

  initial begin
    int c_led, c_red, c_green, c_blue;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    lit("reset_rd", ReadData, 32'd0);
    lit("reset_pwm", {28'd0, led, red, green, blue}, 32'd0);

    for (int i = 0; i < 256; i++) access(32'(i * 4), 1'b1, $urandom, 3'b010);
    access(32'h0, 1'b0, 32'd0, 3'b010);
    check_en = 1'b1;

    access(32'h100, 1'b1, 32'hDEADBEEF, 3'b010);
    access(32'h100, 1'b0, 32'd0, 3'b010);       lit("lw", ReadData, 32'hDEADBEEF);
    access(32'h100, 1'b1, 32'd0, 3'b010);
    access(32'h101, 1'b1, 32'h7F, 3'b000);
    access(32'h100, 1'b0, 32'd0, 3'b010);       lit("sb_lw", ReadData, 32'h00007F00);
    access(32'h100, 1'b1, 32'h80FF0000, 3'b010);
    access(32'h103, 1'b0, 32'd0, 3'b000);       lit("lb", ReadData, 32'hFFFFFF80);
    access(32'h103, 1'b0, 32'd0, 3'b100);       lit("lbu", ReadData, 32'h00000080);
    access(32'h200, 1'b1, 32'h12345678, 3'b010);
    access(32'h202, 1'b1, 32'h8001, 3'b001);
    access(32'h202, 1'b0, 32'd0, 3'b001);       lit("lh", ReadData, 32'hFFFF8001);
    access(32'h202, 1'b0, 32'd0, 3'b101);       lit("lhu", ReadData, 32'h00008001);
    access(32'h200, 1'b0, 32'd0, 3'b101);       lit("lhu_low", ReadData, 32'h00005678);
    access(32'h200, 1'b1, 32'hCAFEF00D, 3'b010); lit("rdw_old", ReadData, 32'h80015678);
    access(32'h8000_0000, 1'b0, 32'd0, 3'b010); lit("unmapped", ReadData, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 1023));
        6:       a = A_LEDS - 32'd3 + 32'($urandom_range(0, 3));
        7:       a = A_MILLIS;
        8:       a = A_MICROS;
        default: a = ($urandom_range(0, 1) == 0) ? 32'h2000 + 32'($urandom_range(0, 4095))
                                                 : 32'hFFFF_FFF0;
      endcase
      access(a, 1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)));
    end

    access(A_LEDS, 1'b1, 32'h804000FF, 3'b010);
    access(A_LEDS, 1'b0, 32'd0, 3'b010);        lit("leds_rd", ReadData, 32'h804000FF);
    c_led = 0; c_red = 0; c_green = 0; c_blue = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      c_led += int'(led); c_red += int'(red); c_green += int'(green); c_blue += int'(blue);
    end
    #1;
    lit("pwm_red", 32'(c_red), 32'd128);
    lit("pwm_green", 32'(c_green), 32'd64);
    lit("pwm_blue", 32'(c_blue), 32'd0);
    lit("pwm_led", 32'(c_led), 32'd255);

    @(posedge clk); #2;
    access(32'h300, 1'b1, 32'h11223344, 3'b010);
    Adr = 32'h300; MemWrite = 1'b1; WriteData = 32'hBAD0BAD0; funct3 = 3'b010;
    reset = 1'b1;
    #1;
    lit("rst_rd", ReadData, 32'd0);
    lit("rst_pwm", {28'd0, led, red, green, blue}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0; MemWrite = 1'b0;
    access(32'h300, 1'b0, 32'd0, 3'b010);       lit("rst_store_dropped", ReadData, 32'h11223344);

    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0; Adr = A_MILLIS;
    repeat (12000) @(posedge clk);
    #2;
    access(A_MILLIS, 1'b0, 32'd0, 3'b010);      lit("millis", ReadData, 32'd1);
    access(A_MICROS, 1'b0, 32'd0, 3'b010);      lit("micros", ReadData, 32'd1000);
    access(A_MICROS, 1'b1, 32'h5555_5555, 3'b010);
    access(A_MICROS, 1'b0, 32'd0, 3'b010);      lit("micros_ro", ReadData, 32'd1000);

    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
